uart_frame_loader: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_frame_loader_byte_timeout.sv | 30 +++
 rtl/uart_frame_loader.sv | 147 ++++++++++++++
 tb/tb_uart_frame_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame loader: FSM states, error codes,
// and the default frame start marker.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_loader_byte_timeout.sv
// Loadable down-counter used as an inter-byte idle watchdog. A clear reloads
// the counter; while enabled it counts down to zero and then flags expiry.
module byte_timeout #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Reload on clear, otherwise count down while enabled and parked at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A clear in the same cycle takes priority over expiry.
  assign expire = en && !clear && (count == '0);

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SYNC, LEN_HI, LEN_LO, PAYLOAD[LEN], CHK frames from the UART byte
// stream, writes the payload into a buffer and reports done or error.
module uart_frame_loader
  import uart_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         MAX_LEN        = 784,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 17360
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic [15:0]           frame_len,
  output logic                  busy
);

  localparam int                    TO_WIDTH  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0]   TO_LOAD   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]           MAX_LEN_W = 16'(MAX_LEN);

  if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 16)) begin : g_bad_addr_width
    $error("uart_frame_loader: ADDR_WIDTH must be in 1..16");
  end
  if (MAX_LEN > (1 << ADDR_WIDTH)) begin : g_bad_max_len
    $error("uart_frame_loader: MAX_LEN exceeds the buffer address space");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_frame_loader: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state;
  state_t      state_d;
  logic [15:0] idx;
  logic [15:0] len;
  logic [7:0]  chk;
  logic        expire;
  logic [15:0] len_word;
  logic        len_ok;
  logic        last_payload;

  assign len_word     = {len[15:8], rx_data};
  assign len_ok       = (len_word != 16'd0) && (len_word <= MAX_LEN_W);
  assign last_payload = (idx == (len - 16'd1));

  byte_timeout #(
    .WIDTH(TO_WIDTH)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (rx_valid),
    .en        (state != IDLE),
    .load_value(TO_LOAD),
    .expire    (expire)
  );

  // Next-state selection; a received byte always beats a timeout expiry.
  always_comb begin
    state_d = state;
    if (rx_valid) begin
      case (state)
        IDLE:    if (rx_data == SYNC_BYTE) state_d = LEN_HI;
        LEN_HI:  state_d = LEN_LO;
        LEN_LO:  state_d = len_ok ? PAYLOAD : IDLE;
        PAYLOAD: if (last_payload) state_d = CHECK;
        CHECK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      state_d = IDLE;
    end
  end

  // State, datapath and registered outputs; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      idx        <= '0;
      len        <= '0;
      chk        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      frame_len  <= '0;
    end else begin
      state      <= state_d;
      busy       <= (state_d != IDLE);
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              idx <= '0;
              len <= '0;
              chk <= '0;
            end
          end
          LEN_HI: begin
            len <= {rx_data, 8'h00};
          end
          LEN_LO: begin
            len <= len_word;
            if (!len_ok) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end
          end
          PAYLOAD: begin
            mem_we    <= 1'b1;
            mem_addr  <= idx[ADDR_WIDTH-1:0];
            mem_wdata <= rx_data;
            chk       <= chk ^ rx_data;
            idx       <= idx + 16'd1;
          end
          CHECK: begin
            if (rx_data == chk) begin
              frame_done <= 1'b1;
              frame_len  <= len;
              err_code   <= ERR_NONE;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
          end
          default: ;
        endcase
      end else if (expire) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: directed frames plus randomized streams. The
// reference scans each recorded byte stream as whole frames and predicts the
// write/done/error events with their cycle numbers.
module tb_uart_frame_loader;

  localparam int         T    = 200;
  localparam int         MAXL = 784;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_len;
  logic        busy;

  uart_frame_loader #(
    .ADDR_WIDTH    (16),
    .MAX_LEN       (MAXL),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .frame_len (frame_len),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = write (a=addr, d=data), 1 = done (d=frame_len), 2 = error (d=err_code)
  typedef struct {
    int t;
    int kind;
    int a;
    int d;
  } ev_t;

  ev_t        expq[$];
  ev_t        gotq[$];
  logic [7:0] s_b[$];
  int         s_t[$];
  int         n_assert = 0;
  int         n_fail = 0;

  // Record every strobe the DUT produces, tagged with its cycle number.
  always @(negedge clk) begin
    if (mem_we === 1'b1)     gotq.push_back('{cyc, 0, int'(mem_addr), int'(mem_wdata)});
    if (frame_done === 1'b1) gotq.push_back('{cyc, 1, 0, int'(frame_len)});
    if (frame_err === 1'b1)  gotq.push_back('{cyc, 2, 0, int'(err_code)});
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    s_b.push_back(b);
    s_t.push_back(cyc);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic push(input int t, input int k, input int a, input int d);
    expq.push_back('{t, k, a, d});
  endtask

  // Bytes of a frame starting at i that arrive without an over-long gap.
  function automatic int run_len(input int i, input int want);
    int c = 1;
    while (c < want && (i + c) < s_b.size() && s_t[i+c] <= s_t[i+c-1] + T) c++;
    return c;
  endfunction

  // Frame broken off after byte k: timeout unless a reset cut the stream there.
  task automatic lost(input int k, input bit cut, input int n);
    if (!(cut && k == n - 1)) push(s_t[k] + T + 1, 2, 0, 3);
  endtask

  task automatic model_run(input bit cut);
    int i = 0;
    int n = s_b.size();
    int c;
    int len;
    logic [7:0] x;
    while (i < n) begin
      if (s_b[i] !== SYNC) begin
        i++;
        continue;
      end
      c = run_len(i, 3);
      if (c < 3) begin
        lost(i + c - 1, cut, n);
        i += c;
        continue;
      end
      len = int'({s_b[i+1], s_b[i+2]});
      if (len == 0 || len > MAXL) begin
        push(s_t[i+2] + 1, 2, 0, 1);
        i += 3;
        continue;
      end
      c = run_len(i, len + 4);
      x = 8'h00;
      for (int p = 0; p < len && p < c - 3; p++) begin
        push(s_t[i+3+p] + 1, 0, p, int'(s_b[i+3+p]));
        x ^= s_b[i+3+p];
      end
      if (c < len + 4) begin
        lost(i + c - 1, cut, n);
        i += c;
        continue;
      end
      if (s_b[i+3+len] == x) push(s_t[i+3+len] + 1, 1, 0, len);
      else                   push(s_t[i+3+len] + 1, 2, 0, 2);
      i += len + 4;
    end
  endtask

  // Let any trailing timeout land, then compare DUT events with the model.
  task automatic check_events(input string tag, input bit cut);
    int m;
    repeat (T + 5) @(negedge clk);
    model_run(cut);
    check({tag, ".count"}, gotq.size(), expq.size());
    m = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.ev%0d.cycle", tag, i), gotq[i].t,    expq[i].t);
      check($sformatf("%s.ev%0d.kind", tag, i),  gotq[i].kind, expq[i].kind);
      check($sformatf("%s.ev%0d.addr", tag, i),  gotq[i].a,    expq[i].a);
      check($sformatf("%s.ev%0d.value", tag, i), gotq[i].d,    expq[i].d);
    end
    gotq.delete();
    expq.delete();
    s_b.delete();
    s_t.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".mem_addr"},   mem_addr,   0);
    check({tag, ".mem_wdata"},  mem_wdata,  0);
    check({tag, ".mem_we"},     mem_we,     0);
    check({tag, ".frame_done"}, frame_done, 0);
    check({tag, ".frame_err"},  frame_err,  0);
    check({tag, ".err_code"},   err_code,   0);
    check({tag, ".frame_len"},  frame_len,  0);
    check({tag, ".busy"},       busy,       0);
  endtask

  function automatic int rgap();
    int r = int'($urandom_range(0, 199));
    if (r < 3) return T - 1;
    if (r < 5) return T + int'($urandom_range(0, 3));
    return int'($urandom_range(0, 3));
  endfunction

  task automatic rand_frame();
    int len;
    int sel;
    logic [7:0] x;
    logic [7:0] b;
    if ($urandom_range(0, 4) == 0) send(8'($urandom), rgap());
    sel = int'($urandom_range(0, 9));
    if (sel == 0)      len = 0;
    else if (sel == 1) len = MAXL + 1 + int'($urandom_range(0, 2000));
    else               len = int'($urandom_range(1, 30));
    send(SYNC, rgap());
    send(8'(len >> 8), rgap());
    send(8'(len), rgap());
    if (len == 0 || len > MAXL) return;
    x = 8'h00;
    for (int p = 0; p < len; p++) begin
      b = 8'($urandom);
      x ^= b;
      send(b, rgap());
    end
    if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
    send(x, rgap());
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] x;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    gotq.delete();

    // Good 3-byte frame
    send(SYNC, 0);
    check("sync.busy", busy, 1);
    send(8'h00, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h44, 0);
    send(8'h77, 0);
    check("good.done", frame_done, 1);
    check("good.len", frame_len, 3);
    check("good.code", err_code, 0);
    check("good.busy", busy, 0);
    check_events("good", 1'b0);

    // Same frame with a bad checksum
    send(SYNC, 0); send(8'h00, 1); send(8'h03, 0); send(8'h11, 2); send(8'h22, 0);
    send(8'h44, 0); send(8'h76, 3);
    check("badchk.err", frame_err, 1);
    check("badchk.done", frame_done, 0);
    check("badchk.code", err_code, 2);
    check("badchk.len", frame_len, 3);
    check_events("badchk", 1'b0);

    // Length zero and length 785
    send(SYNC, 0); send(8'h00, 0); send(8'h00, 0);
    check("len0.err", frame_err, 1);
    check("len0.code", err_code, 1);
    check("len0.busy", busy, 0);
    @(negedge clk);
    check("len0.busy_next", busy, 0);
    send(SYNC, 0); send(8'h03, 0); send(8'h11, 0);
    check("len785.err", frame_err, 1);
    check("len785.code", err_code, 1);
    @(negedge clk);
    check("len785.busy_next", busy, 0);
    check_events("badlen", 1'b0);

    // Leading junk, then SYNC values used as payload and checksum
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    send(SYNC, 0); send(8'h00, 0); send(8'h01, 0); send(SYNC, 0); send(SYNC, 0);
    check("syncdata.done", frame_done, 1);
    check("syncdata.len", frame_len, 1);
    check_events("syncdata", 1'b0);

    // Timeout after a partial frame
    send(SYNC, 0); send(8'h00, 0); send(8'h02, 0); send(8'h11, 0);
    repeat (T - 1) @(negedge clk);
    check("timeout.early", frame_err, 0);
    @(negedge clk);
    check("timeout.err", frame_err, 1);
    check("timeout.code", err_code, 3);
    check("timeout.busy", busy, 0);
    check_events("timeout", 1'b0);

    // Strobe landing on the expiry cycle beats the timeout
    send(SYNC, 0); send(8'h00, 0); send(8'h02, 0); send(8'h11, 0);
    send(8'h22, T - 1);
    send(8'h33, T - 1);
    check("edge.done", frame_done, 1);
    check("edge.code", err_code, 0);
    check("edge.len", frame_len, 2);
    check_events("edge", 1'b0);

    // Largest accepted frame
    send(SYNC, 0); send(8'(MAXL >> 8), 0); send(8'(MAXL), 0);
    x = 8'h00;
    for (int p = 0; p < MAXL; p++) begin
      b = 8'($urandom);
      x ^= b;
      send(b, 0);
    end
    send(x, 0);
    check("maxlen.done", frame_done, 1);
    check("maxlen.len", frame_len, MAXL);
    check_events("maxlen", 1'b0);

    // Reset in the middle of a payload, then a normal frame
    send(SYNC, 0); send(8'h00, 0); send(8'h04, 0); send(8'h01, 0); send(8'h02, 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    check_events("midreset", 1'b1);
    send(SYNC, 0); send(8'h00, 0); send(8'h02, 0); send(8'h5A, 0); send(8'hC3, 0);
    send(8'h99, 0);
    check("afterreset.done", frame_done, 1);
    check("afterreset.len", frame_len, 2);
    check_events("afterreset", 1'b0);

    // Randomized streams
    for (int s = 0; s < 12; s++) begin
      for (int f = 0; f < 3; f++) rand_frame();
      check_events($sformatf("rand%0d", s), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
